coprocessor0_regfile: RTL and testbench
=======================================

COPROCESSOR0_REGFILE -- requirements
Module: coprocessor0_regfile

Interface
REQ-001 SHALL have parameter COUNT_DIVIDE, default 2, meaning clock cycles per Count increment; legal values are 1 or 2.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port wb_to_cp0_bus, input, WBToCP0Data, the MTC0 write from writeback; its address fields also select the MFC0 read.
REQ-005 SHALL have port read_data, output, CpuData, combinational read of the register addressed by wb_to_cp0_bus.
REQ-006 SHALL have port exception_valid, input, 1, a commit-time exception this cycle.
REQ-007 SHALL have ports exception_code (input, 5), exception_pc (input, CpuData), exception_in_delay_slot (input, 1), giving the cause, faulting PC and branch-delay flag.
REQ-008 SHALL have ports bad_vaddr_valid (input, 1) and bad_vaddr (input, CpuData), giving the address-error virtual address.
REQ-009 SHALL have port eret, input, 1, an ERET committing this cycle.
REQ-010 SHALL have port hardware_interrupt, input, 6, level-sensitive external interrupt lines.
REQ-011 SHALL have outputs status (StatusData), cause (CauseData) and epc (EPCData), the registered values.
REQ-012 SHALL have output interrupt_pending, 1, meaning an enabled interrupt is to be taken.

Function
REQ-013 SHALL map the registers as: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, all at select 0.
REQ-014 SHALL read 0 for any unmapped register or nonzero select.
REQ-015 SHALL ignore writes to unmapped registers, to nonzero selects, and to BadVAddr.
REQ-016 SHALL make only these fields writable: Status interrupt_mask, exception_level and interrupt_enabled; Cause software_interrupt; all of EPC, Count and Compare. All other bits hold their value.
REQ-017 SHALL increment Count by 1, with 32-bit wrap from 0xFFFFFFFF to 0, once every COUNT_DIVIDE cycles, using an internal phase bit.
REQ-018 SHALL, on a write to Count, load the written value, discard that cycle's increment and clear the phase bit.
REQ-019 SHALL set Cause.timer_interrupt on the cycle after registered Count equals Compare; the bit is sticky.
REQ-020 SHALL clear Cause.timer_interrupt on a write to Compare; if a match occurs in the same cycle, the clear wins.
REQ-021 SHALL register hardware_interrupt into Cause.hardware_interrupt every cycle, giving 1-cycle latency.
REQ-022 SHALL, on exception_valid with Status.exception_level=0, load EPC with exception_pc-4 if exception_in_delay_slot, else exception_pc, and load Cause.in_delay_slot with exception_in_delay_slot.
REQ-023 SHALL, on every exception_valid, set Status.exception_level to 1 and load Cause.exception_code; if exception_level was already 1, EPC and in_delay_slot are unchanged.
REQ-024 SHALL load BadVAddr from bad_vaddr only when exception_valid and bad_vaddr_valid are both high.
REQ-025 SHALL clear Status.exception_level on eret.
REQ-026 SHALL give priority exception_valid > eret > MTC0 within one cycle; lower-priority actions that cycle are dropped entirely.
REQ-027 SHALL compute interrupt_pending combinationally as interrupt_enabled AND NOT exception_level AND OR of (interrupt_mask AND {hardware_interrupt[5] OR timer_interrupt, hardware_interrupt[4:0], software_interrupt}).
REQ-028 SHALL complete all writes in one cycle, so a read on the following cycle returns the new value; there is no same-cycle bypass.

Reset
REQ-029 SHALL, on reset, set Status to boot_exception_vector=1 with all other bits 0 (0x00400000).
REQ-030 SHALL, on reset, clear Cause, EPC, BadVAddr, Count, Compare and the phase bit to 0, so interrupt_pending=0.
REQ-031 SHALL give reset priority over exception_valid, eret and MTC0 in the same cycle.

Structure
REQ-032 SHALL place CP0 register-number constants, the Status reset value and an exception-code enum (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12) in coprocessor0_params.
REQ-033 SHALL implement Count, Compare, the phase bit and the timer match in one sub-module, cp0_timer.

Verification
REQ-034 SHALL cover: reset, then MFC0 of 12, 13 and 14 -> reads 0x00400000, 0 and 0; interrupt_pending=0.
REQ-035 SHALL cover: exception_valid with code 4, pc 0xBFC00100, delay slot 1, bad_vaddr 0x1235 -> next cycle EPC=0xBFC000FC, Cause.BD=1, ExcCode=4, EXL=1, BadVAddr=0x1235.
REQ-036 SHALL cover: a second exception with code 8 and pc 0x80000010 while EXL=1 -> EPC unchanged, ExcCode=8; then eret -> EXL=0.
REQ-037 SHALL cover: Compare=5, Count=0 with COUNT_DIVIDE=2 -> timer_interrupt rises about 11 cycles later; with Status=0x00008001 interrupt_pending=1; writing Compare clears it.
REQ-038 SHALL cover: exception_valid, eret and MTC0 of EPC=0x1234 in the same cycle -> only the exception takes effect; EPC is not 0x1234.
REQ-039 SHALL cover: Count written 0xFFFFFFFF -> two increments later reads 0.

Source files
------------

// File: rtl/coprocessor0_regfile_pkg.sv
// CP0 shared types: bus bundle, register layouts,
// register numbers and exception codes.
package coprocessor0_params;

  typedef logic [31:0] CpuData;
  typedef CpuData EPCData;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic       write_enable;
    logic [4:0] address;
    logic [2:0] select;
    CpuData     data;
  } WBToCP0Data;

  typedef struct packed {
    logic [8:0] zero_31_23;
    logic       boot_exception_vector;
    logic [5:0] zero_21_16;
    logic [7:0] interrupt_mask;
    logic [5:0] zero_7_2;
    logic       exception_level;
    logic       interrupt_enabled;
  } StatusData;

  typedef struct packed {
    logic        in_delay_slot;
    logic        timer_interrupt;
    logic [13:0] zero_29_16;
    logic [5:0]  hardware_interrupt;
    logic [1:0]  software_interrupt;
    logic        zero_7;
    logic [4:0]  exception_code;
    logic [1:0]  zero_1_0;
  } CauseData;

  localparam StatusData STATUS_RESET = 32'h0040_0000;

  function automatic logic hits(
    WBToCP0Data b,
    logic [4:0] r
  );
    return b.select == 3'd0 && b.address == r;
  endfunction

endpackage

// File: rtl/coprocessor0_regfile_if.sv
// MTC0/MFC0 bus between writeback and CP0.
// The timer only observes the write half.
import coprocessor0_params::*;

interface coprocessor0_regfile_if;
  WBToCP0Data wb_to_cp0_bus;
  CpuData     read_data;

  modport master (
    output wb_to_cp0_bus,
    input  read_data
  );
  modport slave (
    input  wb_to_cp0_bus,
    output read_data
  );
  modport timer (
    input  wb_to_cp0_bus
  );
endinterface

// File: rtl/coprocessor0_regfile_timer.sv
// CP0 Count/Compare pair with prescale phase
// and the registered-value match.
module cp0_timer
  import coprocessor0_params::*;
#(
  parameter int COUNT_DIVIDE = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   write_allowed,
  coprocessor0_regfile_if.timer bus,
  output CpuData count,
  output CpuData compare,
  output logic   compare_write,
  output logic   match
);

  localparam bit DIV1 = (COUNT_DIVIDE == 1);

  logic phase;
  logic tick;
  logic count_write;

  assign count_write = write_allowed
    && bus.wb_to_cp0_bus.write_enable
    && hits(bus.wb_to_cp0_bus, CP0_COUNT);

  assign compare_write = write_allowed
    && bus.wb_to_cp0_bus.write_enable
    && hits(bus.wb_to_cp0_bus, CP0_COMPARE);

  assign tick  = DIV1 | phase;
  assign match = (count == compare);

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      phase   <= 1'b0;
    end else begin
      // a Count write restarts the prescaler
      if (count_write) begin
        count <= bus.wb_to_cp0_bus.data;
        phase <= 1'b0;
      end else begin
        if (tick)
          count <= count + 32'd1;
        phase <= DIV1 ? 1'b0 : ~phase;
      end
      if (compare_write)
        compare <= bus.wb_to_cp0_bus.data;
    end
  end

endmodule

// File: rtl/coprocessor0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr,
// exception entry, ERET and interrupt pending.
module coprocessor0_regfile
  import coprocessor0_params::*;
#(
  parameter int COUNT_DIVIDE = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  WBToCP0Data wb_to_cp0_bus,
  output CpuData     read_data,
  input  logic       exception_valid,
  input  logic [4:0] exception_code,
  input  CpuData     exception_pc,
  input  logic       exception_in_delay_slot,
  input  logic       bad_vaddr_valid,
  input  CpuData     bad_vaddr,
  input  logic       eret,
  input  logic [5:0] hardware_interrupt,
  output StatusData  status,
  output CauseData   cause,
  output EPCData     epc,
  output logic       interrupt_pending
);

  coprocessor0_regfile_if wb_if ();

  CpuData     bad_vaddr_q;
  CpuData     count;
  CpuData     compare;
  CpuData     rd;
  logic       compare_write;
  logic       timer_match;
  logic       mtc0_allowed;
  logic       mtc0;
  logic [7:0] irq_lines;

  assign wb_if.wb_to_cp0_bus = wb_to_cp0_bus;
  assign wb_if.read_data     = rd;
  assign read_data           = wb_if.read_data;

  // exception beats eret beats MTC0
  assign mtc0_allowed = !exception_valid && !eret;
  assign mtc0 = mtc0_allowed
    && wb_to_cp0_bus.write_enable;

  cp0_timer #(
    .COUNT_DIVIDE (COUNT_DIVIDE)
  ) u_timer (
    .clock         (clock),
    .reset         (reset),
    .write_allowed (mtc0_allowed),
    .bus           (wb_if),
    .count         (count),
    .compare       (compare),
    .compare_write (compare_write),
    .match         (timer_match)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      status <= STATUS_RESET;
    end else if (exception_valid) begin
      status.exception_level <= 1'b1;
    end else if (eret) begin
      status.exception_level <= 1'b0;
    end else if (mtc0
                 && hits(wb_to_cp0_bus, CP0_STATUS)) begin
      status.interrupt_mask    <= wb_to_cp0_bus.data[15:8];
      status.exception_level   <= wb_to_cp0_bus.data[1];
      status.interrupt_enabled <= wb_to_cp0_bus.data[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cause <= '0;
    end else begin
      cause.hardware_interrupt <= hardware_interrupt;
      cause.timer_interrupt <= compare_write ? 1'b0
        : (cause.timer_interrupt | timer_match);
      if (exception_valid) begin
        cause.exception_code <= exception_code;
        if (!status.exception_level)
          cause.in_delay_slot <= exception_in_delay_slot;
      end else if (mtc0 && !eret
                   && hits(wb_to_cp0_bus, CP0_CAUSE)) begin
        cause.software_interrupt <= wb_to_cp0_bus.data[9:8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      epc         <= '0;
      bad_vaddr_q <= '0;
    end else begin
      if (exception_valid) begin
        // nested exceptions keep the original return point
        if (!status.exception_level)
          epc <= exception_in_delay_slot
            ? exception_pc - 32'd4 : exception_pc;
      end else if (mtc0
                   && hits(wb_to_cp0_bus, CP0_EPC)) begin
        epc <= wb_to_cp0_bus.data;
      end
      if (exception_valid && bad_vaddr_valid)
        bad_vaddr_q <= bad_vaddr;
    end
  end

  always_comb begin
    rd = '0;
    if (wb_to_cp0_bus.select == 3'd0) begin
      unique case (wb_to_cp0_bus.address)
        CP0_BADVADDR: rd = bad_vaddr_q;
        CP0_COUNT:    rd = count;
        CP0_COMPARE:  rd = compare;
        CP0_STATUS:   rd = status;
        CP0_CAUSE:    rd = cause;
        CP0_EPC:      rd = epc;
        default:      rd = '0;
      endcase
    end
  end

  assign irq_lines = {
    cause.hardware_interrupt[5] | cause.timer_interrupt,
    cause.hardware_interrupt[4:0],
    cause.software_interrupt
  };

  assign interrupt_pending = status.interrupt_enabled
    & ~status.exception_level
    & |(status.interrupt_mask & irq_lines);

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Bench for coprocessor0_regfile: directed table,
// corner sequences, random run against a word model.
module tb_coprocessor0_regfile;
  import coprocessor0_params::*;

  localparam int DIV = 2;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [2:0]  sel;
  logic [31:0] data;
  logic        exc_v;
  logic [4:0]  code;
  logic [31:0] pc;
  logic        ds;
  logic        bv_v;
  logic [31:0] bv;
  logic        eret_i;
  logic [5:0]  hw;
  StatusData   status;
  CauseData    cause;
  EPCData      epc;
  logic        pend;

  int n_cmp = 0;
  int n_bad = 0;

  coprocessor0_regfile_if bus ();

  assign bus.wb_to_cp0_bus = '{write_enable: we,
    address: addr, select: sel, data: data};

  coprocessor0_regfile #(
    .COUNT_DIVIDE (DIV)
  ) dut (
    .clock                   (clk),
    .reset                   (rst),
    .wb_to_cp0_bus           (bus.wb_to_cp0_bus),
    .read_data               (bus.read_data),
    .exception_valid         (exc_v),
    .exception_code          (code),
    .exception_pc            (pc),
    .exception_in_delay_slot (ds),
    .bad_vaddr_valid         (bv_v),
    .bad_vaddr               (bv),
    .eret                    (eret_i),
    .hardware_interrupt      (hw),
    .status                  (status),
    .cause                   (cause),
    .epc                     (epc),
    .interrupt_pending       (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  // model: whole 32-bit words, Count as base + elapsed/DIV
  logic [31:0]     m_status;
  logic            m_bd;
  logic            m_ti;
  logic [5:0]      m_hw;
  logic [1:0]      m_sw;
  logic [4:0]      m_exc;
  logic [31:0]     m_epc;
  logic [31:0]     m_bva;
  logic [31:0]     m_base;
  longint unsigned m_ticks;
  logic [31:0]     m_compare;

  function automatic logic [31:0] mcount();
    return 32'(longint'(m_base) + m_ticks / DIV);
  endfunction

  function automatic logic [31:0] mcause();
    return {m_bd, m_ti, 14'd0, m_hw, m_sw,
            1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] mread(
    logic [4:0] a, logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:    return m_bva;
      5'd9:    return mcount();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return mcause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic mpending();
    logic [7:0] lines;
    lines = {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    return m_status[0] && !m_status[1]
      && ((m_status[15:8] & lines) != 8'd0);
  endfunction

  task automatic model_step();
    logic [31:0] cnt;
    logic        hit;
    logic        w;
    cnt = mcount();
    hit = (cnt == m_compare);
    w   = !exc_v && !eret_i && we && sel == 3'd0;
    if (rst) begin
      m_status = 32'h0040_0000;
      {m_bd, m_ti, m_hw, m_sw, m_exc} = '0;
      m_epc = 0; m_bva = 0; m_base = 0;
      m_ticks = 0; m_compare = 0;
      return;
    end
    m_hw = hw;
    if (w && addr == 5'd11) begin
      m_compare = data;
      m_ti = 1'b0;
    end else begin
      m_ti = m_ti | hit;
    end
    if (w && addr == 5'd9) begin
      m_base = data;
      m_ticks = 0;
    end else begin
      m_ticks++;
    end
    if (exc_v) begin
      if (!m_status[1]) begin
        m_epc = ds ? pc - 32'd4 : pc;
        m_bd  = ds;
      end
      m_status[1] = 1'b1;
      m_exc = code;
      if (bv_v) m_bva = bv;
    end else if (eret_i) begin
      m_status[1] = 1'b0;
    end else if (w) begin
      case (addr)
        5'd12: m_status = (m_status & ~32'h0000_FF03)
                        | (data & 32'h0000_FF03);
        5'd13: m_sw = data[9:8];
        5'd14: m_epc = data;
        default: ;
      endcase
    end
  endtask

  task automatic chk(string name,
                     logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic idle(logic [4:0] a);
    we = 0; addr = a; sel = 0; data = 0;
    exc_v = 0; code = 0; pc = 0; ds = 0;
    bv_v = 0; bv = 0; eret_i = 0;
  endtask

  // inputs set after negedge; check, clock, advance model
  task automatic step();
    #1;
    chk("read_data", bus.read_data, mread(addr, sel));
    chk("status", status, m_status);
    chk("cause", cause, mcause());
    chk("epc", epc, m_epc);
    chk("pending", {31'd0, pend}, {31'd0, mpending()});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [31:0] data;
    logic        exc_v;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        ds;
    logic        bv_v;
    logic [31:0] bv;
    logic        eret;
    logic [31:0] exp_rd;
    logic        exp_pend;
  } vec_t;

  function automatic vec_t rd_row(
    logic [4:0] a, logic [31:0] e, logic p);
    vec_t v;
    v = '{1'b0, a, 3'd0, 32'd0, 1'b0, 5'd0, 32'd0,
          1'b0, 1'b0, 32'd0, 1'b0, e, p};
    return v;
  endfunction

  function automatic vec_t wr_row(logic [4:0] a,
    logic [2:0] s, logic [31:0] d,
    logic [31:0] e, logic p);
    vec_t v;
    v = rd_row(a, e, p);
    v.we = 1'b1; v.sel = s; v.data = d;
    return v;
  endfunction

  vec_t tbl[33];
  int   n;

  initial begin
    tbl[0]  = rd_row(13, 32'h0000_0000, 0);
    tbl[1]  = rd_row(12, 32'h0040_0000, 0);
    tbl[2]  = rd_row(14, 32'h0000_0000, 0);
    tbl[3]  = rd_row(8,  32'h0000_0000, 0);
    tbl[3].exc_v = 1; tbl[3].code = EXC_ADEL;
    tbl[3].pc = 32'hBFC0_0100; tbl[3].ds = 1;
    tbl[3].bv_v = 1; tbl[3].bv = 32'h1235;
    tbl[4]  = rd_row(14, 32'hBFC0_00FC, 0);
    tbl[5]  = rd_row(8,  32'h0000_1235, 0);
    tbl[6]  = rd_row(12, 32'h0040_0002, 0);
    tbl[7]  = rd_row(13, 32'hC000_0010, 0);
    tbl[8]  = rd_row(14, 32'hBFC0_00FC, 0);
    tbl[8].exc_v = 1; tbl[8].code = EXC_SYS;
    tbl[8].pc = 32'h8000_0010;
    tbl[9]  = rd_row(14, 32'hBFC0_00FC, 0);
    tbl[10] = rd_row(13, 32'hC000_0020, 0);
    tbl[11] = rd_row(12, 32'h0040_0002, 0);
    tbl[11].eret = 1;
    tbl[12] = rd_row(12, 32'h0040_0000, 0);
    tbl[13] = wr_row(14, 0, 32'h1234, 32'hBFC0_00FC, 0);
    tbl[13].exc_v = 1; tbl[13].code = EXC_OV;
    tbl[13].pc = 32'h100; tbl[13].eret = 1;
    tbl[14] = rd_row(14, 32'h0000_0100, 0);
    tbl[15] = rd_row(12, 32'h0040_0002, 0);
    tbl[16] = rd_row(13, 32'h4000_0030, 0);
    tbl[16].eret = 1;
    tbl[17] = wr_row(8, 0, 32'hFFFF, 32'h1235, 0);
    tbl[18] = rd_row(8, 32'h1235, 0);
    tbl[19] = wr_row(12, 1, 32'hFFFF_FFFF, 0, 0);
    tbl[20] = rd_row(12, 32'h0040_0000, 0);
    tbl[21] = wr_row(12, 0, 32'hFFFF_FFFF,
                     32'h0040_0000, 0);
    tbl[22] = rd_row(12, 32'h0040_FF03, 0);
    tbl[23] = wr_row(12, 0, 0, 32'h0040_FF03, 0);
    tbl[24] = rd_row(12, 32'h0040_0000, 0);
    tbl[25] = wr_row(13, 0, 32'hFFFF_FFFF,
                     32'h4000_0030, 0);
    tbl[26] = rd_row(13, 32'h4000_0330, 0);
    tbl[27] = wr_row(12, 0, 32'h101, 32'h0040_0000, 0);
    tbl[28] = rd_row(12, 32'h0040_0101, 1);
    tbl[29] = wr_row(13, 0, 0, 32'h4000_0330, 1);
    tbl[30] = rd_row(13, 32'h4000_0030, 0);
    tbl[31] = wr_row(12, 0, 0, 32'h0040_0101, 0);
    tbl[32] = rd_row(12, 32'h0040_0000, 0);

    idle(13); hw = 0; rst = 1;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      we = tbl[i].we; addr = tbl[i].addr;
      sel = tbl[i].sel; data = tbl[i].data;
      exc_v = tbl[i].exc_v; code = tbl[i].code;
      pc = tbl[i].pc; ds = tbl[i].ds;
      bv_v = tbl[i].bv_v; bv = tbl[i].bv;
      eret_i = tbl[i].eret;
      #1;
      chk($sformatf("tbl%0d_rd", i),
          bus.read_data, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_pend", i),
          {31'd0, pend}, {31'd0, tbl[i].exp_pend});
      step();
    end

    // timer: Compare=5, Count=0, wait for the match
    idle(12); we = 1; data = 32'h0000_8001; step();
    idle(11); we = 1; data = 32'd5; step();
    chk("ti_cleared", {31'd0, cause.timer_interrupt}, 0);
    idle(9); we = 1; data = 32'd0; step();
    idle(13);
    n = 0;
    while (n < 30 && !cause.timer_interrupt) begin
      step();
      n++;
    end
    chk("timer_latency", n, 11);
    chk("timer_pending", {31'd0, pend}, 1);
    idle(11); we = 1; data = 32'h1000; step();
    idle(13);
    #1;
    chk("ti_after_cmp", {31'd0, cause.timer_interrupt}, 0);
    chk("pend_after_cmp", {31'd0, pend}, 0);
    step();

    // Count wrap
    idle(9); we = 1; data = 32'hFFFF_FFFF; step();
    idle(9);
    #1 chk("wrap_0", bus.read_data, 32'hFFFF_FFFF);
    step();
    #1 chk("wrap_1", bus.read_data, 32'hFFFF_FFFF);
    step();
    #1 chk("wrap_2", bus.read_data, 32'h0);
    step();

    // hardware line 0 is seen one cycle later
    idle(12); we = 1; data = 32'h0000_0401; step();
    idle(13); hw = 6'b000001;
    #1 chk("hw_same_cycle", {31'd0, pend}, 0);
    step();
    #1 chk("hw_next_cycle", {31'd0, pend}, 1);
    chk("hw_cause", {26'd0, cause.hardware_interrupt}, 1);
    step();
    hw = 0;

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(99) == 0);
      we    = ($urandom_range(2) == 0);
      case ($urandom_range(6))
        0: addr = 5'd8;
        1: addr = 5'd9;
        2: addr = 5'd11;
        3: addr = 5'd12;
        4: addr = 5'd13;
        5: addr = 5'd14;
        default: addr = 5'($urandom);
      endcase
      sel   = ($urandom_range(7) == 0) ? 3'($urandom) : 3'd0;
      data  = ($urandom_range(3) == 0)
            ? 32'($urandom_range(63)) : $urandom;
      exc_v = ($urandom_range(9) == 0);
      eret_i = ($urandom_range(9) == 0);
      code  = 5'($urandom);
      pc    = $urandom;
      ds    = 1'($urandom);
      bv_v  = 1'($urandom);
      bv    = $urandom;
      if ($urandom_range(3) == 0) hw = 6'($urandom);
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
